// File: rtl/shift_unit_if.sv
// Handshake and data bundle between the ALU stage, the serial shifter and the C-bus consumer.
// master drives operations and out_ready; slave is the shifter.
interface shift_unit_if #(
  parameter int NBITS = 32,
  parameter int SHW   = $clog2(NBITS)
);
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] y;
  logic [1:0]       op;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] c;
  logic             n_flag;
  logic             z_flag;
  logic             busy;

  modport master (
    output in_valid, y, op, shamt, out_ready,
    input  in_ready, out_valid, c, n_flag, z_flag, busy
  );

  modport slave (
    input  in_valid, y, op, shamt, out_ready,
    output in_ready, out_valid, c, n_flag, z_flag, busy
  );
endinterface

// File: rtl/shift_unit.sv
// Serial one-bit-per-cycle shifter between the ALU result and the C-bus,
// with valid/ready on both sides and N/Z flags latched on each delivered result.
//
// state | meaning
// IDLE  | ready for a new operation, c holds the last result
// SHIFT | one shift per cycle, count runs down to 1
// DONE  | result presented on c until the consumer takes it
module shift_unit #(
  parameter int NBITS = 32,
  parameter int SHW   = $clog2(NBITS)
) (
  input  logic           clk,
  input  logic           reset,
  shift_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_SRL  = 2'b10;

  state_t           state, state_nx;
  logic [NBITS-1:0] data;
  logic [1:0]       op_q;
  logic [SHW-1:0]   count;

  logic             out_valid_q, out_valid_nx;
  logic [NBITS-1:0] c_q, c_nx;
  logic             n_q, n_nx;
  logic             z_q, z_nx;
  logic             in_ready_c;
  logic             accept;
  logic             handshake;
  logic [NBITS-1:0] shifted;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.op == OP_PASS || bus.shamt == '0) state_nx = DONE;
          else                                      state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (count == SHW'(1)) state_nx = DONE;
      end
      DONE: begin
        if (handshake) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // out_valid drops on the handshake edge itself so a result is never taken twice
  always_comb begin
    in_ready_c   = (state == IDLE) && !reset;
    accept       = bus.in_valid && in_ready_c;
    handshake    = out_valid_q && bus.out_ready;
    out_valid_nx = (state == DONE) && !handshake;
    c_nx         = (state == DONE) ? data : c_q;
    n_nx         = handshake ? c_q[NBITS-1] : n_q;
    z_nx         = handshake ? (c_q == '0) : z_q;
  end

  always_comb begin
    case (op_q)
      OP_SLL:  shifted = {data[NBITS-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, data[NBITS-1:1]};
      default: shifted = {data[NBITS-1], data[NBITS-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data        <= '0;
      op_q        <= OP_PASS;
      count       <= '0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
    end else begin
      if (accept) begin
        data  <= bus.y;
        op_q  <= bus.op;
        count <= bus.shamt;
      end else if (state == SHIFT) begin
        data  <= shifted;
        count <= count - SHW'(1);
      end
      out_valid_q <= out_valid_nx;
      c_q         <= c_nx;
      n_q         <= n_nx;
      z_q         <= z_nx;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.n_flag    = n_q;
  assign bus.z_flag    = z_q;

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit: directed operations push expected results,
// an independent monitor checks c, latency, flags and handshake rules.
module tb_shift_unit;

  typedef struct {
    logic [31:0] c;
    int          lat;
    logic        n;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_count = 0;
  exp_t exp_q[$];
  int   accept_q[$];

  shift_unit_if #(.NBITS(32)) bus ();

  shift_unit #(.NBITS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // accept log, used by the monitor to measure latency
  always @(posedge clk) begin
    if (reset) accept_q.delete();
    else if (bus.in_valid && bus.in_ready) begin
      accept_q.push_back(cyc);
      accept_count++;
    end
    cyc <= cyc + 1;
  end

  // monitor: samples 1 time unit after each falling edge
  initial begin : monitor
    logic prev_ov, prev_or, prev_n, prev_z, prev_rst, pend;
    logic pend_n, pend_z;
    exp_t e;
    int   acc;
    prev_ov = 0; prev_or = 0; prev_n = 0; prev_z = 0; prev_rst = 1; pend = 0;
    pend_n = 0; pend_z = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        pend = 0;
      end else begin
        if (pend) begin
          check("flag_n_after_hs", 32'(bus.n_flag), 32'(pend_n));
          check("flag_z_after_hs", 32'(bus.z_flag), 32'(pend_z));
          pend = 0;
        end else if (!prev_rst) begin
          check("flags_hold", {30'd0, bus.n_flag, bus.z_flag}, {30'd0, prev_n, prev_z});
        end
        if (prev_ov && !prev_or && !prev_rst)
          check("out_valid_hold", 32'(bus.out_valid), 32'd1);
        if (exp_q.size() != 0)
          check("in_ready_busy", 32'(bus.in_ready), 32'd0);
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
          end else begin
            e = exp_q[0];
            if (!prev_ov) begin
              if (accept_q.size() == 0) begin
                check("accept_seen", 32'd0, 32'd1);
              end else begin
                acc = accept_q.pop_front();
                check("latency", 32'(cyc - 1 - acc), 32'(e.lat));
              end
            end
            check("c_value", bus.c, e.c);
            if (bus.out_ready) begin
              pend   = 1;
              pend_n = e.n;
              pend_z = e.z;
              void'(exp_q.pop_front());
            end
          end
        end
      end
      prev_ov  = bus.out_valid;
      prev_or  = bus.out_ready;
      prev_n   = bus.n_flag;
      prev_z   = bus.z_flag;
      prev_rst = reset;
    end
  end

  task automatic wait_in_ready();
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("complete_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] y, input logic [4:0] sh,
                       input logic [31:0] ec, input int lat, input logic en, input logic ez);
    exp_t e;
    wait_in_ready();
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.y        = y;
    bus.shamt    = sh;
    @(negedge clk);
    bus.in_valid = 1'b0;
    e.c = ec; e.lat = lat; e.n = en; e.z = ez;
    exp_q.push_back(e);
    wait_idle();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e;
    int   acc1;
    int   n;
    bus.in_valid  = 1'b0;
    bus.y         = '0;
    bus.op        = 2'b00;
    bus.shamt     = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;

    // reset behaviour
    repeat (2) @(negedge clk);
    check("rst_c", bus.c, 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_flags", {30'd0, bus.n_flag, bus.z_flag}, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // op, y, shamt, expected c, latency, N, Z
    issue(2'b01, 32'h0000_00FF, 5'd8,  32'h0000_FF00, 9, 1'b0, 1'b0);
    issue(2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000, 5, 1'b1, 1'b0);
    issue(2'b10, 32'h8000_0000, 5'd4,  32'h0800_0000, 5, 1'b0, 1'b0);
    issue(2'b10, 32'h0000_0001, 5'd1,  32'h0000_0000, 2, 1'b0, 1'b1);
    issue(2'b00, 32'h1234_5678, 5'd31, 32'h1234_5678, 1, 1'b0, 1'b0);
    issue(2'b01, 32'h0000_0003, 5'd31, 32'h8000_0000, 32, 1'b1, 1'b0);
    issue(2'b11, 32'h8000_0001, 5'd0,  32'h8000_0001, 1, 1'b1, 1'b0);
    issue(2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678, 1, 1'b0, 1'b0);

    // output stall with in_valid held high
    wait_in_ready();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = 2'b00;
    bus.y         = 32'hFFFF_FFFF;
    bus.shamt     = 5'd7;
    @(negedge clk);
    e.c = 32'hFFFF_FFFF; e.lat = 1; e.n = 1'b1; e.z = 1'b0;
    exp_q.push_back(e);
    acc1   = accept_count;
    bus.y  = 32'h0000_0000;
    bus.op = 2'b01;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_out_valid_seen", 32'(bus.out_valid), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_flags", {30'd0, bus.n_flag, bus.z_flag}, 32'd0);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    wait_idle();
    check("stall_single_accept", 32'(accept_count), 32'(acc1));
    check("stall_flags_final", {30'd0, bus.n_flag, bus.z_flag}, 32'd2);

    // reset abort in the middle of a long shift
    wait_in_ready();
    bus.in_valid = 1'b1;
    bus.op       = 2'b01;
    bus.y        = 32'h0000_0001;
    bus.shamt    = 5'd20;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_c", bus.c, 32'd0);
    check("abort_flags", {30'd0, bus.n_flag, bus.z_flag}, 32'd0);
    check("abort_in_ready_rst", 32'(bus.in_ready), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_c_idle", bus.c, 32'd0);
    repeat (25) begin
      @(negedge clk);
      check("abort_no_out_valid", 32'(bus.out_valid), 32'd0);
    end
    issue(2'b10, 32'h0000_00F0, 5'd4, 32'h0000_000F, 5, 1'b0, 1'b0);
    check("final_c_held", bus.c, 32'h0000_000F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
Name: shift_unit

Overview:
- Multi-cycle serial shifter directly downstream of the ALU in the datapath; consumes the ALU result and drives the C-bus value.
- Shifts the ALU result by 0..NBITS-1 positions, one bit per cycle, with a valid/ready handshake on input and output.
- Latches the N and Z status flags from each delivered result for microsequencer branch decisions.

Parameters:
NBITS, 32 (from shared definitions), datapath width.
SHW, $clog2(NBITS) = 5, shift-amount width.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  ALU result and controls valid.
in_ready  output  1  unit can accept a new operation.
y  input  NBITS  ALU result to shift.
op  input  2  00 PASS, 01 SLL, 10 SRL, 11 SRA.
shamt  input  SHW  shift amount.
out_valid  output  1  result on c is valid.
out_ready  input  1  consumer accepts c.
c  output  NBITS  shifted result.
n_flag  output  1  latched sign of last delivered result.
z_flag  output  1  latched zero of last delivered result.
busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (synchronous, takes priority over all other events):
  - state=IDLE, data register=0, count=0, c=0, out_valid=0, n_flag=0, z_flag=0, busy=0.
  - in_ready=0 while reset is high.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept on in_valid && in_ready: latch y into data, latch op, load count=shamt.
  - If op==PASS or shamt==0, go to DONE; otherwise go to SHIFT.
- SHIFT:
  - in_ready=0. Each cycle shift data by one bit and decrement count.
  - SLL: shift left, zero fill. SRL: shift right, zero fill. SRA: shift right, fill with data[NBITS-1].
  - Go to DONE on the cycle the shift with count==1 is performed.
- DONE:
  - out_valid=1, c=data.
  - Hold c and out_valid stable until out_ready=1.
  - On out_valid && out_ready: n_flag<=c[NBITS-1], z_flag<=(c==0), go to IDLE.
  - No input acceptance in DONE; no overlap between input and output transactions.
- Latency: out_valid rises shamt+1 cycles after the accept edge (1 cycle for PASS or shamt==0). Throughput is one operation per latency+1 cycles minimum.
- Flags change only on an output handshake and hold otherwise. Flags are never updated during SHIFT.
- c is a register; it is 0 after reset and holds its last value in IDLE.
- in_valid while busy: ignored. Inputs are not sampled and no state is affected.
- PASS ignores shamt.
- shamt is at most NBITS-1 by width; no overflow handling is needed.
- Reset in SHIFT or DONE aborts the operation: no out_valid, flags cleared, IDLE on the next cycle.
- out_ready high in IDLE or SHIFT has no effect.
- All outputs are registered except in_ready and busy, which are decoded from the state register.

Test Plan:
1. Assert reset for 2 cycles -> c=0, out_valid=0, n_flag=0, z_flag=0, in_ready=0 during reset and 1 the cycle after release.
2. SLL, y=0x000000FF, shamt=8, out_ready=1 -> out_valid 9 cycles after accept, c=0x0000FF00, flags after handshake N=0, Z=0; in_ready=0 throughout.
3. SRA, y=0x80000000, shamt=4 -> latency 5, c=0xF8000000, N=1, Z=0. Repeat with SRL -> c=0x08000000, N=0.
4. SRL, y=0x00000001, shamt=1 -> latency 2, c=0, Z=1. Then PASS, y=0x12345678, shamt=31 -> latency 1, c=0x12345678, Z=0.
5. PASS y=0xFFFFFFFF with out_ready low for 3 cycles and in_valid held high -> c and out_valid stable, in_ready=0, second input not taken, flags unchanged until the out_ready cycle, then N=1, Z=0.
6. SLL shamt=20 with reset pulsed at cycle 5 after accept -> no out_valid ever, c=0, flags=0, IDLE with in_ready=1 after reset drops; a new operation then completes normally.
